regfile_read_pipe: RTL and testbench



---
 rtl/regfile_read_pipe.sv | 84 ++++++++
 tb/tb_regfile_read_pipe.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_pipe.sv
// Register file with one write port, NREAD registered read ports,
// write-first forwarding, an optional hardwired zero register and stall refresh.
module regfile_read_pipe #(
    parameter int  WIDTH    = 64,
    parameter int  DEPTH    = 32,
    parameter int  NREAD    = 2,
    parameter int  ZERO_EN  = 1,
    parameter int  ZERO_REG = DEPTH - 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        wr_en,
    input  logic [AW-1:0]               wr_addr,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic [NREAD-1:0]            rd_req,
    input  logic [NREAD-1:0][AW-1:0]    rd_addr,
    input  logic                        stall,
    output logic [NREAD-1:0][WIDTH-1:0] rd_data,
    output logic [NREAD-1:0]            rd_valid
);

    localparam logic [AW-1:0] ZIDX = AW'(ZERO_REG);
    localparam logic          ZEN  = (ZERO_EN != 0);

    function automatic logic is_zero(input logic [AW-1:0] a);
        return ZEN && (a == ZIDX);
    endfunction

    logic [WIDTH-1:0]            regs [DEPTH];
    logic [NREAD-1:0][AW-1:0]    held_addr;
    logic [NREAD-1:0][AW-1:0]    held_addr_d;
    logic [NREAD-1:0][WIDTH-1:0] rd_data_d;
    logic [NREAD-1:0]            rd_valid_d;
    logic                        wr_ok;

    assign wr_ok = wr_en && !is_zero(wr_addr);

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                regs[i] <= '0;
            end else if (wr_ok && wr_addr == AW'(i)) begin
                regs[i] <= wr_data;
            end
        end
    end

    // A stalled port keeps tracking the register it captured.
    always_comb begin
        rd_data_d   = rd_data;
        rd_valid_d  = rd_valid;
        held_addr_d = held_addr;
        for (int p = 0; p < NREAD; p++) begin
            if (!stall) begin
                rd_valid_d[p]  = rd_req[p];
                held_addr_d[p] = rd_addr[p];
                if (is_zero(rd_addr[p])) begin
                    rd_data_d[p] = '0;
                end else if (wr_en && wr_addr == rd_addr[p]) begin
                    rd_data_d[p] = wr_data;
                end else begin
                    rd_data_d[p] = regs[rd_addr[p]];
                end
            end else if (wr_en && wr_addr == held_addr[p]
                         && !is_zero(held_addr[p])) begin
                rd_data_d[p] = wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data   <= '0;
            rd_valid  <= '0;
            held_addr <= '0;
        end else begin
            rd_data   <= rd_data_d;
            rd_valid  <= rd_valid_d;
            held_addr <= held_addr_d;
        end
    end

endmodule

// File: tb/tb_regfile_read_pipe.sv
// Scoreboard bench: default instance (64x32, 2 ports, XZR=r31) and a
// 32x16, 4-port instance with the zero register disabled, on one stimulus stream.
module tb_regfile_read_pipe;

    logic            clk;
    logic            rst_n;
    logic            wen;
    logic            stall;
    logic [4:0]      waddr;
    logic [63:0]     wdata;
    logic [3:0]      req;
    logic [3:0][4:0] addr;

    logic [1:0][4:0]  aa;
    logic [1:0][63:0] da;
    logic [1:0]       va;
    logic [3:0][3:0]  ab;
    logic [3:0][31:0] db;
    logic [3:0]       vb;

    int tests = 0;
    int fails = 0;

    assign aa = addr[1:0];
    always_comb begin
        for (int p = 0; p < 4; p++) ab[p] = addr[p][3:0];
    end

    regfile_read_pipe u_a (
        .clk     (clk),
        .reset_n (rst_n),
        .wr_en   (wen),
        .wr_addr (waddr),
        .wr_data (wdata),
        .rd_req  (req[1:0]),
        .rd_addr (aa),
        .stall   (stall),
        .rd_data (da),
        .rd_valid(va)
    );

    regfile_read_pipe #(
        .WIDTH   (32),
        .DEPTH   (16),
        .NREAD   (4),
        .ZERO_EN (0),
        .ZERO_REG(15)
    ) u_b (
        .clk     (clk),
        .reset_n (rst_n),
        .wr_en   (wen),
        .wr_addr (waddr[3:0]),
        .wr_data (wdata[31:0]),
        .rd_req  (req),
        .rd_addr (ab),
        .stall   (stall),
        .rd_data (db),
        .rd_valid(vb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a port's output is always the current contents of the
    // register it last captured; the zero register simply never changes.
    logic [63:0] ma [32];
    logic [31:0] mb [16];
    int          ha [2];
    int          hb [4];
    logic [1:0]  vam;
    logic [3:0]  vbm;

    typedef struct {
        logic [1:0][63:0] ea;
        logic [1:0]       eva;
        logic [3:0][31:0] eb;
        logic [3:0]       evb;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        exp_t e;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) ma[i] = '0;
            for (int i = 0; i < 16; i++) mb[i] = '0;
            for (int p = 0; p < 2; p++) ha[p] = 0;
            for (int p = 0; p < 4; p++) hb[p] = 0;
            vam = '0;
            vbm = '0;
        end else begin
            if (wen && waddr != 5'd31) ma[waddr] = wdata;
            if (wen) mb[waddr[3:0]] = wdata[31:0];
            if (!stall) begin
                for (int p = 0; p < 2; p++) begin
                    ha[p]  = int'(addr[p]);
                    vam[p] = req[p];
                end
                for (int p = 0; p < 4; p++) begin
                    hb[p]  = int'(addr[p][3:0]);
                    vbm[p] = req[p];
                end
            end
        end
        for (int p = 0; p < 2; p++) e.ea[p] = ma[ha[p]];
        for (int p = 0; p < 4; p++) e.eb[p] = mb[hb[p]];
        e.eva = vam;
        e.evb = vbm;
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("A.data[%0d]", p), da[p], e.ea[p]);
            end
            chk("A.valid", 64'(va), 64'(e.eva));
            for (int p = 0; p < 4; p++) begin
                chk($sformatf("B.data[%0d]", p), 64'(db[p]), 64'(e.eb[p]));
            end
            chk("B.valid", 64'(vb), 64'(e.evb));
        end
    end

    task automatic cyc();
        step();
        @(negedge clk);
    endtask

    task automatic idle();
        wen   = 1'b0;
        stall = 1'b0;
        req   = '0;
        waddr = '0;
        wdata = '0;
        addr  = '0;
    endtask

    function automatic logic [4:0] pick();
        logic [4:0] pool [4];
        pool[0] = 5'd3;
        pool[1] = 5'd4;
        pool[2] = 5'd15;
        pool[3] = 5'd31;
        if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 3)];
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            wen   = 1'b1;
            waddr = 5'($urandom);
            wdata = {$urandom, $urandom};
            req   = 4'($urandom);
            stall = 1'($urandom);
            for (int p = 0; p < 4; p++) addr[p] = 5'($urandom);
            cyc();
        end
        chk("rst.A.valid", 64'(va), 64'd0);
        chk("rst.A.data0", da[0], 64'd0);
        chk("rst.B.valid", 64'(vb), 64'd0);

        rst_n = 1'b1;
        idle();
        cyc();
        for (int i = 0; i < 32; i++) begin
            req = 4'hF;
            for (int p = 0; p < 4; p++) addr[p] = 5'(i);
            cyc();
        end

        idle();
        wen   = 1'b1;
        waddr = 5'd5;
        wdata = 64'hDEADBEEF_00000005;
        cyc();
        idle();
        req[0]  = 1'b1;
        addr[0] = 5'd5;
        cyc();
        chk("wr_rd.data", da[0], 64'hDEADBEEF_00000005);
        chk("wr_rd.valid", 64'(va[0]), 64'd1);

        idle();
        wen   = 1'b1;
        waddr = 5'd7;
        wdata = 64'h11;
        cyc();
        wdata   = 64'h22;
        req     = 4'hF;
        addr[0] = 5'd7;
        addr[1] = 5'd7;
        cyc();
        chk("fwd.p0", da[0], 64'h22);
        chk("fwd.p1", da[1], 64'h22);

        idle();
        wen     = 1'b1;
        waddr   = 5'd31;
        wdata   = '1;
        req     = 4'hF;
        addr[0] = 5'd31;
        addr[1] = 5'd31;
        cyc();
        chk("zero.fwd", da[0], 64'd0);
        chk("zero.off.fwd", 64'(db[0]), 64'hFFFF_FFFF);
        wen = 1'b0;
        cyc();
        chk("zero.next", da[1], 64'd0);
        chk("zero.off.next", 64'(db[1]), 64'hFFFF_FFFF);

        idle();
        wen   = 1'b1;
        waddr = 5'd3;
        wdata = 64'hA;
        cyc();
        idle();
        req[1]  = 1'b1;
        addr[1] = 5'd3;
        cyc();
        chk("stall.cap", da[1], 64'hA);
        idle();
        stall   = 1'b1;
        req[1]  = 1'b0;
        addr[1] = 5'd9;
        cyc();
        wen   = 1'b1;
        waddr = 5'd3;
        wdata = 64'hB;
        cyc();
        chk("stall.refresh", da[1], 64'hB);
        chk("stall.valid", 64'(va[1]), 64'd1);
        waddr = 5'd4;
        wdata = 64'hC;
        cyc();
        chk("stall.other", da[1], 64'hB);
        idle();
        req[1]  = 1'b1;
        addr[1] = 5'd4;
        cyc();
        chk("release.r4", da[1], 64'hC);

        for (int k = 0; k < 10000; k++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            stall = ($urandom_range(0, 2) == 0);
            wen   = 1'($urandom);
            waddr = pick();
            wdata = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom};
            req   = 4'($urandom);
            for (int p = 0; p < 4; p++) addr[p] = pick();
            if (!rst_n) begin
                #1;
                chk("async.A.valid", 64'(va), 64'd0);
                chk("async.A.data1", da[1], 64'd0);
                chk("async.B.data3", 64'(db[3]), 64'd0);
            end
            cyc();
        end

        rst_n = 1'b1;
        idle();
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard.drained", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
